// File: rtl/psram_pkg.sv
// Shared PSRAM definitions: bus widths, arbiter state encoding and the latched
// command payload handed to the controller.
package psram_pkg;

  localparam int unsigned PSRAM_ADDR_W = 22;
  localparam int unsigned PSRAM_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    GUARD = 2'd2,
    WAIT  = 2'd3
  } psram_state_e;

  typedef struct packed {
    logic                    we;
    logic                    byte_wr;
    logic [PSRAM_ADDR_W-1:0] addr;
    logic [PSRAM_DATA_W-1:0] din;
  } psram_cmd_t;

endpackage

// File: rtl/psram_rr_pick.sv
// Combinational round-robin pick: first requesting port after `last`, wrapping
// modulo NPORTS. Shared by multi-master blocks on the PSRAM side.
module psram_rr_pick #(
  parameter int unsigned NPORTS = 2,
  localparam int unsigned IDX_W = $clog2(NPORTS)
) (
  input  logic [NPORTS-1:0] req,
  input  logic [IDX_W-1:0]  last,
  output logic [IDX_W-1:0]  grant_idx,
  output logic              any
);

  assign any = |req;

  // Scan from the farthest candidate back to last+1 so the nearest one wins.
  always_comb begin
    grant_idx = '0;
    for (int i = NPORTS; i >= 1; i--) begin
      if (req[IDX_W'((32'(last) + 32'(i)) % NPORTS)]) begin
        grant_idx = IDX_W'((32'(last) + 32'(i)) % NPORTS);
      end
    end
  end

endmodule

// File: rtl/psram_arbiter.sv
// Round-robin arbiter sharing one PSRAM controller between NPORTS requesters,
// with one-cycle strobes, a busy guard cycle and a per-transaction timeout.
module psram_arbiter
  import psram_pkg::*;
#(
  parameter int unsigned NPORTS  = 2,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NPORTS-1:0]                req,
  input  logic [NPORTS-1:0]                req_we,
  input  logic [NPORTS-1:0]                req_byte,
  input  logic [NPORTS*PSRAM_ADDR_W-1:0]   req_addr,
  input  logic [NPORTS*PSRAM_DATA_W-1:0]   req_din,
  output logic [NPORTS-1:0]                ack,
  output logic [NPORTS-1:0]                done,
  output logic [PSRAM_DATA_W-1:0]          rdata,
  output logic                             err,
  output logic                             timeout,
  output logic                             mem_read,
  output logic                             mem_write,
  output logic                             mem_byte_write,
  output logic [PSRAM_ADDR_W-1:0]          mem_addr,
  output logic [PSRAM_DATA_W-1:0]          mem_din,
  input  logic [PSRAM_DATA_W-1:0]          mem_dout,
  input  logic                             mem_busy
);

  localparam int unsigned IDX_W  = $clog2(NPORTS);
  localparam int unsigned WCNT_W = $clog2(TIMEOUT);
  localparam logic [IDX_W-1:0]  LAST_RST = IDX_W'(NPORTS - 1);
  localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(TIMEOUT - 1);

  psram_cmd_t          req_cmd [NPORTS];
  psram_cmd_t          pick_cmd;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_any;

  psram_state_e        state_q;
  logic [IDX_W-1:0]    last_q;
  logic [IDX_W-1:0]    gnt_q;
  psram_cmd_t          cmd_q;
  logic [WCNT_W-1:0]   wcnt_q;
  logic [NPORTS-1:0]   ack_q;
  logic [NPORTS-1:0]   done_q;
  logic [PSRAM_DATA_W-1:0] rdata_q;
  logic                err_q;
  logic                timeout_q;
  logic                mem_read_q;
  logic                mem_write_q;

  // Unpack the flat per-port command buses.
  for (genvar p = 0; p < NPORTS; p++) begin : g_unpack
    assign req_cmd[p] = {req_we[p], req_byte[p],
                         req_addr[p*PSRAM_ADDR_W +: PSRAM_ADDR_W],
                         req_din[p*PSRAM_DATA_W +: PSRAM_DATA_W]};
  end

  psram_rr_pick #(
    .NPORTS(NPORTS)
  ) u_pick (
    .req      (req),
    .last     (last_q),
    .grant_idx(pick_idx),
    .any      (pick_any)
  );

  assign pick_cmd = req_cmd[pick_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      last_q      <= LAST_RST;
      gnt_q       <= '0;
      cmd_q       <= '0;
      wcnt_q      <= '0;
      ack_q       <= '0;
      done_q      <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      timeout_q   <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      ack_q       <= '0;
      done_q      <= '0;
      err_q       <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;

      unique case (state_q)
        // Grant only once the controller is idle (covers its init phase).
        IDLE: begin
          if (pick_any && !mem_busy) begin
            gnt_q         <= pick_idx;
            last_q        <= pick_idx;
            cmd_q         <= pick_cmd;
            cmd_q.byte_wr <= pick_cmd.byte_wr & pick_cmd.we;
            ack_q         <= NPORTS'(1) << pick_idx;
            mem_read_q    <= ~pick_cmd.we;
            mem_write_q   <= pick_cmd.we;
            state_q       <= CMD;
          end
        end
        CMD: begin
          state_q <= GUARD;
        end
        // Controller busy is registered, so ignore it for one cycle.
        GUARD: begin
          wcnt_q  <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (!mem_busy) begin
            rdata_q <= mem_dout;
            done_q  <= NPORTS'(1) << gnt_q;
            state_q <= IDLE;
          end else if (wcnt_q == WCNT_MAX) begin
            rdata_q   <= '0;
            done_q    <= NPORTS'(1) << gnt_q;
            err_q     <= 1'b1;
            timeout_q <= 1'b1;
            state_q   <= IDLE;
          end else begin
            wcnt_q <= wcnt_q + WCNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ack            = ack_q;
  assign done           = done_q;
  assign rdata          = rdata_q;
  assign err            = err_q;
  assign timeout        = timeout_q;
  assign mem_read       = mem_read_q;
  assign mem_write      = mem_write_q;
  assign mem_byte_write = cmd_q.byte_wr;
  assign mem_addr       = cmd_q.addr;
  assign mem_din        = cmd_q.din;

endmodule
